// File: rtl/cnna_div_pkg.sv
// Shared widths, saturation limits and FSM states for the CNNA requant divider.
package cnna_div_pkg;

    localparam int unsigned DIVIDEND_W = 32;
    localparam int unsigned DIVISOR_W  = 15;
    localparam int unsigned QUOT_W     = 26;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W + 1);

    localparam logic [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    // Quotient magnitudes at which the signed result stops fitting in QUOT_W bits.
    localparam logic [DIVIDEND_W-1:0] QMAX_MAG = DIVIDEND_W'(QMAX);
    localparam logic [DIVIDEND_W-1:0] QMIN_MAG = DIVIDEND_W'(QMIN);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/cnna_div_restoring_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module cnna_div_restoring_step
    import cnna_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] prem,
    input  logic                 bit_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   prem_next,
    output logic                 qbit
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] diff;

    always_comb begin
        shifted   = {prem, bit_in};
        diff      = {1'b0, shifted} - {2'b00, divisor};
        // No borrow out means the trial difference is non-negative.
        qbit      = ~diff[DIVISOR_W+1];
        prem_next = qbit ? diff[DIVISOR_W:0] : shifted;
    end

endmodule

// File: rtl/cnna_div_32s_15ns_26s_seq.sv
// Sequential signed / unsigned divider with saturated 26-bit quotient, valid/ready on both sides.
module cnna_div_32s_15ns_26s_seq
    import cnna_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W:0]    remainder,
    output logic                  overflow,
    output logic                  div_by_zero
);

    state_e                state_q, state_d;
    logic [DIVIDEND_W-1:0] mag_q, mag_d;
    logic [DIVIDEND_W-2:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  prem_q, prem_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [QUOT_W-1:0]     quotient_q, quotient_d;
    logic [DIVISOR_W:0]    remainder_q, remainder_d;
    logic                  overflow_q, overflow_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_qbit;
    logic [DIVIDEND_W-1:0] qmag;
    logic [QUOT_W-1:0]     res_quot;
    logic [DIVISOR_W:0]    res_rem;
    logic                  res_ovf, res_dbz;

    cnna_div_restoring_step u_step (
        .prem      (prem_q),
        .bit_in    (mag_q[DIVIDEND_W-1]),
        .divisor   (dvs_q),
        .prem_next (step_rem),
        .qbit      (step_qbit)
    );

    // Result of the final iteration, with sign fix-up and saturation.
    always_comb begin
        qmag     = {quo_q, step_qbit};
        res_ovf  = 1'b0;
        res_dbz  = 1'b0;
        res_rem  = neg_q ? ({(DIVISOR_W+1){1'b0}} - step_rem) : step_rem;
        res_quot = neg_q ? ({QUOT_W{1'b0}} - qmag[QUOT_W-1:0]) : qmag[QUOT_W-1:0];
        if (dvs_q == '0) begin
            res_dbz  = 1'b1;
            res_rem  = '0;
            res_quot = neg_q ? QMIN : QMAX;
        end else if (!neg_q && (qmag > QMAX_MAG)) begin
            res_ovf  = 1'b1;
            res_quot = QMAX;
        end else if (neg_q && (qmag > QMIN_MAG)) begin
            res_ovf  = 1'b1;
            res_quot = QMIN;
        end
    end

    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        in_ready    = (state_q == StIdle);
        out_valid   = (state_q == StDone);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Two's-complement negate in DIVIDEND_W bits maps -2^31 to 2^31 unsigned.
                    neg_d   = dividend[DIVIDEND_W-1];
                    mag_d   = dividend[DIVIDEND_W-1] ? ({DIVIDEND_W{1'b0}} - dividend) : dividend;
                    dvs_d   = divisor;
                    prem_d  = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                mag_d  = {mag_q[DIVIDEND_W-2:0], 1'b0};
                quo_d  = {quo_q[DIVIDEND_W-3:0], step_qbit};
                prem_d = step_rem[DIVISOR_W-1:0];
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    quotient_d  = res_quot;
                    remainder_d = res_rem;
                    overflow_d  = res_ovf;
                    dbz_d       = res_dbz;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cnna_div_32s_15ns_26s_seq.sv
// Bench for the sequential requant divider: directed table, stall/abort sequences, random scoreboard.
module tb_cnna_div_32s_15ns_26s_seq;

    typedef struct packed {
        logic [31:0] a;
        logic [14:0] b;
        logic [25:0] q;
        logic [15:0] r;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [43:0] exp;
        int unsigned acc;
    } sb_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [14:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] quotient;
    logic [15:0] remainder;
    logic        overflow;
    logic        div_by_zero;

    logic        man_rdy;
    logic        rand_rdy;
    logic        rnd_bit = 1'b1;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    sb_t         sb[$];
    vec_t        tbl[12];

    cnna_div_32s_15ns_26s_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;
    always @(posedge ap_clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign out_ready = rand_rdy ? rnd_bit : man_rdy;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // C-style truncating division with 26-bit saturation; packs {q, r, ovf, dbz}.
    function automatic logic [43:0] model(input logic [31:0] a, input logic [14:0] b);
        longint sa, sd, q, r;
        logic   o, z;
        logic [25:0] qq;
        logic [15:0] rr;
        sa = longint'($signed(a));
        sd = longint'(b);
        o  = 1'b0;
        z  = 1'b0;
        if (b == 15'd0) begin
            z = 1'b1;
            r = 0;
            q = (sa < 0) ? -33554432 : 33554431;
        end else begin
            q = sa / sd;
            r = sa % sd;
            if (q > 33554431) begin
                q = 33554431;
                o = 1'b1;
            end else if (q < -33554432) begin
                q = -33554432;
                o = 1'b1;
            end
        end
        qq = q[25:0];
        rr = r[15:0];
        return {qq, rr, o, z};
    endfunction

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [14:0] b, input logic [43:0] exp);
        int  n;
        sb_t e;
        n        = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (n < 300) begin
            @(negedge ap_clk);
            if (in_ready) break;
            n++;
        end
        if (n >= 300) begin
            check(1'b0, "accept_timeout", 64'(n), 64'd300);
        end else begin
            e.exp = exp;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge ap_clk);
        #1;
        // Scramble the operands after acceptance; the captured values must not change.
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 15'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check(1'b0, "drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_monitor();
        sb_t cur;
        bit  have_cur;
        have_cur = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (ap_rst) begin
                have_cur = 1'b0;
            end else if (out_valid) begin
                check(!in_ready, "in_ready_in_done", 64'(in_ready), 64'd0);
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_result", 64'(quotient), 64'd0);
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1'b1;
                        check((cyc - cur.acc) == 33, "latency", 64'(cyc - cur.acc), 64'd33);
                    end
                end
                if (have_cur) begin
                    check({quotient, remainder, overflow, div_by_zero} == cur.exp, "result",
                          64'({quotient, remainder, overflow, div_by_zero}), 64'(cur.exp));
                    if (out_ready) have_cur = 1'b0;
                end
            end else if (have_cur) begin
                check(1'b0, "valid_dropped", 64'd0, 64'd1);
                have_cur = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [14:0] b;
        bit          seen;
        int          n;

        tbl[0]  = '{a: 32'd1000,        b: 15'd7,     q: 26'd142,       r: 16'd6,    o: 1'b0, z: 1'b0};
        tbl[1]  = '{a: 32'(-1000),      b: 15'd7,     q: 26'(-142),     r: 16'(-6),  o: 1'b0, z: 1'b0};
        tbl[2]  = '{a: 32'd1000,        b: 15'd32767, q: 26'd0,         r: 16'd1000, o: 1'b0, z: 1'b0};
        tbl[3]  = '{a: 32'd2147483646,  b: 15'd32767, q: 26'd65538,     r: 16'd0,    o: 1'b0, z: 1'b0};
        tbl[4]  = '{a: 32'd2147483647,  b: 15'd1,     q: 26'd33554431,  r: 16'd0,    o: 1'b1, z: 1'b0};
        tbl[5]  = '{a: 32'h8000_0000,   b: 15'd1,     q: 26'h200_0000,  r: 16'd0,    o: 1'b1, z: 1'b0};
        tbl[6]  = '{a: 32'd5,           b: 15'd0,     q: 26'd33554431,  r: 16'd0,    o: 1'b0, z: 1'b1};
        tbl[7]  = '{a: 32'(-5),         b: 15'd0,     q: 26'h200_0000,  r: 16'd0,    o: 1'b0, z: 1'b1};
        tbl[8]  = '{a: 32'd0,           b: 15'd5,     q: 26'd0,         r: 16'd0,    o: 1'b0, z: 1'b0};
        tbl[9]  = '{a: 32'(-7),         b: 15'd2,     q: 26'(-3),       r: 16'(-1),  o: 1'b0, z: 1'b0};
        tbl[10] = '{a: 32'd33554432,    b: 15'd1,     q: 26'd33554431,  r: 16'd0,    o: 1'b1, z: 1'b0};
        tbl[11] = '{a: 32'(-33554432),  b: 15'd1,     q: 26'h200_0000,  r: 16'd0,    o: 1'b0, z: 1'b0};

        ap_rst   = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        man_rdy  = 1'b1;
        rand_rdy = 1'b0;
        fork
            run_monitor();
        join_none

        repeat (3) step();
        check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        check(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        check(quotient == '0, "reset_quotient", 64'(quotient), 64'd0);
        check(remainder == '0, "reset_remainder", 64'(remainder), 64'd0);
        check({overflow, div_by_zero} == 2'b00, "reset_flags", 64'({overflow, div_by_zero}), 64'd0);
        ap_rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].a, tbl[i].b, {tbl[i].q, tbl[i].r, tbl[i].o, tbl[i].z});
        end
        drain();

        // Stall in DONE for 10 cycles, then release and issue a back-to-back operation.
        man_rdy = 1'b0;
        send(32'd1000, 15'd7, {26'd142, 16'd6, 1'b0, 1'b0});
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        check(out_valid == 1'b1, "hold_reach_done", 64'(out_valid), 64'd1);
        repeat (10) begin
            step();
            check(!in_ready && out_valid, "hold_stall", 64'({in_ready, out_valid}), 64'b01);
        end
        man_rdy = 1'b1;
        step();
        check(in_ready && !out_valid, "done_to_idle", 64'({in_ready, out_valid}), 64'b10);
        send(32'(-1000), 15'd7, {26'(-142), 16'(-6), 1'b0, 1'b0});
        drain();

        // Abort mid-calculation; nothing from that operation may emerge.
        send(32'd1000, 15'd7, {26'd142, 16'd6, 1'b0, 1'b0});
        repeat (10) step();
        ap_rst = 1'b1;
        step();
        check(in_ready && !out_valid, "abort_idle", 64'({in_ready, out_valid}), 64'b10);
        ap_rst = 1'b0;
        sb.delete();
        seen = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check(!seen, "abort_no_result", 64'(seen), 64'd0);
        send(32'd1000, 15'd7, {26'd142, 16'd6, 1'b0, 1'b0});
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            repeat ($urandom_range(0, 2)) step();
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 2000)) - 32'd1000;
                1:       a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 + 32'($urandom_range(0, 9))
                                                         : 32'h7fff_fff0 + 32'($urandom_range(0, 15));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 15))
                0:       b = 15'd0;
                1, 2:    b = 15'($urandom_range(1, 15));
                default: b = 15'($urandom_range(0, 32767));
            endcase
            send(a, b, model(a, b));
        end
        drain();
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
